// File: rtl/axi_traffic_gen_if.sv
// AXI-style bus bundle between axi_traffic_gen and the memory slave it exercises.
//   master modport : traffic generator side (drives valids/addresses/write data, rready/bready)
//   slave  modport : memory/controller side (drives readies, write response, read data)
`timescale 1ns/1ps
interface axi_traffic_gen_if #(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
    output arvalid, araddr, arlen, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata, rlast
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
    input  arvalid, araddr, arlen, rready,
    output awready, wready, bvalid, arready, rvalid, rdata, rlast
  );
endinterface

// File: rtl/axi_traffic_gen.sv
// Traffic master for DDR2 controller bring-up. Writes NUM_BURSTS bursts of BURST_LEN beats at
// START_ADDR + b*ADDR_STRIDE with data SEED + global beat index; in MODE=1 it then reads every
// burst back and counts mismatching beats.
// Ports:
//   clk, rst      : single clock, synchronous active-high reset
//   start         : run trigger (level or pulse), only honoured in idle with init_end high
//   init_end      : controller initialisation complete
//   axi           : AXI-style master bus (AW/W/B/AR/R channels)
//   busy          : run in progress
//   done          : one-cycle pulse at end of run
//   pass          : err_cnt was zero at done, held until the next start
//   err_cnt       : saturating count of bad read beats
`timescale 1ns/1ps
module axi_traffic_gen #(
  parameter int unsigned           ADDR_WIDTH  = 27,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           BURST_LEN   = 8,
  parameter int unsigned           NUM_BURSTS  = 4,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0,
  parameter int unsigned           ADDR_STRIDE = 64,
  parameter logic [DATA_WIDTH-1:0] SEED        = '0,
  parameter int unsigned           MODE        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              init_end,
  axi_traffic_gen_if.master axi,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt
);

  localparam logic [7:0]            LastBeat  = 8'(BURST_LEN - 1);
  localparam int unsigned           BW        = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [BW-1:0]         LastBurst = BW'(NUM_BURSTS - 1);
  localparam logic [BW-1:0]         BOne      = BW'(1);
  localparam logic [ADDR_WIDTH-1:0] Stride    = ADDR_WIDTH'(ADDR_STRIDE);
  localparam logic [DATA_WIDTH-1:0] DOne      = DATA_WIDTH'(1);

  typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StFin} state_e;

  state_e                state_q;
  logic [BW-1:0]         b_q;
  logic [DATA_WIDTH-1:0] g_q;
  logic [DATA_WIDTH-1:0] rg_q;
  logic [7:0]            beat_q;     // beat within the current burst, shared by W and R
  logic [ADDR_WIDTH-1:0] addr_q;     // current burst address, drives both awaddr and araddr
  logic [7:0]            len_q;
  logic                  awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  busy_q, done_q, pass_q;
  logic [15:0]           err_q;

  logic                  last_burst;
  logic                  last_beat;
  logic                  r_bad;
  logic [DATA_WIDTH-1:0] r_exp;
  logic [15:0]           err_d;

  // Read-beat check: data against the write pattern, rlast against the local beat count.
  always_comb begin
    last_burst = (b_q == LastBurst);
    last_beat  = (beat_q == LastBeat);
    r_exp      = SEED + rg_q;
    r_bad      = (axi.rdata != r_exp) || (axi.rlast != last_beat);
    err_d      = (r_bad && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      b_q       <= '0;
      g_q       <= '0;
      rg_q      <= '0;
      beat_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start && init_end) begin
            state_q   <= StAw;
            busy_q    <= 1'b1;
            pass_q    <= 1'b0;
            err_q     <= '0;
            b_q       <= '0;
            g_q       <= '0;
            rg_q      <= '0;
            beat_q    <= '0;
            addr_q    <= START_ADDR;
            len_q     <= LastBeat;
            awvalid_q <= 1'b1;
          end
        end
        StAw: begin
          if (axi.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wdata_q   <= SEED + g_q;
            wlast_q   <= (LastBeat == 8'd0);
            beat_q    <= '0;
            state_q   <= StW;
          end
        end
        StW: begin
          if (axi.wready) begin
            g_q <= g_q + DOne;
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= StB;
            end else begin
              beat_q  <= beat_q + 8'd1;
              wdata_q <= SEED + g_q + DOne;
              wlast_q <= ((beat_q + 8'd1) == LastBeat);
            end
          end
        end
        StB: begin
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            if (!last_burst) begin
              b_q       <= b_q + BOne;
              addr_q    <= addr_q + Stride;
              awvalid_q <= 1'b1;
              state_q   <= StAw;
            end else if (MODE == 1) begin
              b_q       <= '0;
              addr_q    <= START_ADDR;
              arvalid_q <= 1'b1;
              state_q   <= StAr;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              pass_q  <= (err_q == 16'd0);
              state_q <= StFin;
            end
          end
        end
        StAr: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= StR;
          end
        end
        StR: begin
          if (axi.rvalid) begin
            err_q  <= err_d;
            rg_q   <= rg_q + DOne;
            beat_q <= beat_q + 8'd1;
            // Burst end follows the local beat count; a misplaced rlast is only an error.
            if (last_beat) begin
              rready_q <= 1'b0;
              if (!last_burst) begin
                b_q       <= b_q + BOne;
                addr_q    <= addr_q + Stride;
                arvalid_q <= 1'b1;
                state_q   <= StAr;
              end else begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                pass_q  <= (err_d == 16'd0);
                state_q <= StFin;
              end
            end
          end
        end
        StFin: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wlast   = wlast_q;
  assign axi.bready  = bready_q;
  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.rready  = rready_q;

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_axi_traffic_gen.sv
`timescale 1ns/1ps
module tb_axi_traffic_gen;
  localparam int unsigned BL0   = 8;
  localparam logic [31:0] SEED0 = 32'h0000_0000;
  localparam logic [31:0] SEED8 = 32'h0000_00A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start8, init_end;
  logic busy, done, pass, busy8, done8, pass8;
  logic [15:0] err_cnt, err_cnt8;

  axi_traffic_gen_if #(.ADDR_WIDTH(27), .DATA_WIDTH(32)) bus ();
  axi_traffic_gen_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus8 ();

  axi_traffic_gen #(
    .ADDR_WIDTH(27), .DATA_WIDTH(32), .BURST_LEN(8), .NUM_BURSTS(4), .START_ADDR(27'd0),
    .ADDR_STRIDE(64), .SEED(SEED0), .MODE(1)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .init_end(init_end), .axi(bus),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
  );

  axi_traffic_gen #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .BURST_LEN(1), .NUM_BURSTS(3), .START_ADDR(8'hF0),
    .ADDR_STRIDE(16), .SEED(SEED8), .MODE(0)
  ) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .init_end(init_end), .axi(bus8),
    .busy(busy8), .done(done8), .pass(pass8), .err_cnt(err_cnt8)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Scoreboard queues
  logic [31:0] q_aw[$], q_ar[$], q_aw8[$];
  logic [32:0] q_w[$], q_w8[$];
  logic [16:0] q_done[$], q_done8[$];

  logic stall_en    = 1'b0;
  int   corrupt_idx = -1;
  int   rd_glob     = 0;
  logic lat_en      = 1'b0;
  int   last_aw     = -1;
  int   cyc         = 0;

  task automatic push_run0(input logic pass_exp, input logic [15:0] err_exp);
    logic [31:0] addrs [4];
    addrs = '{32'd0, 32'd64, 32'd128, 32'd192};
    for (int b = 0; b < 4; b++) begin
      q_aw.push_back(addrs[b]);
      q_ar.push_back(addrs[b]);
    end
    for (int i = 0; i < 32; i++) q_w.push_back({(i % 8) == 7, SEED0 + 32'(i)});
    q_done.push_back({pass_exp, err_exp});
  endtask

  task automatic push_run8();
    logic [31:0] addrs [3];
    addrs = '{32'h0F0, 32'h000, 32'h010};
    for (int b = 0; b < 3; b++) begin
      q_aw8.push_back(addrs[b]);
      q_w8.push_back({1'b1, SEED8 + 32'(b)});
    end
    q_done8.push_back({1'b1, 16'd0});
  endtask

  // Memory slave for the MODE=1 instance
  logic [31:0] mem [logic [31:0]];
  initial begin
    logic pend_b;
    int rd_left, rd_beat;
    logic [31:0] wa, ra;
    pend_b = 1'b0; rd_left = 0; rd_beat = 0; wa = '0; ra = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rlast = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_b = 1'b0; rd_left = 0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0;
      end else begin
        if (rd_left > 0 && (!stall_en || $urandom_range(0, 1) == 1)) begin
          bus.rvalid = 1'b1;
          bus.rdata  = mem[ra] ^ {31'd0, rd_glob == corrupt_idx};
          bus.rlast  = (rd_beat == BL0 - 1);
          if (bus.rready) begin
            ra += 4; rd_beat++; rd_left--; rd_glob++;
          end
        end else begin
          bus.rvalid = 1'b0;
          bus.rlast  = 1'b0;
        end
        bus.arready = 1'b1;
        if (bus.arvalid) begin
          ra = 32'(bus.araddr); rd_left = BL0; rd_beat = 0;
        end
        bus.bvalid = pend_b;
        if (pend_b && bus.bready) pend_b = 1'b0;
        bus.awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.awvalid && bus.awready) wa = 32'(bus.awaddr);
        bus.wready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.wvalid && bus.wready) begin
          mem[wa] = bus.wdata;
          wa += 4;
          if (bus.wlast) pend_b = 1'b1;
        end
      end
    end
  end

  // Write-only slave for the MODE=0 instance
  initial begin
    logic pend_b8;
    pend_b8 = 1'b0;
    bus8.awready = 1'b0; bus8.wready = 1'b0; bus8.bvalid = 1'b0;
    bus8.arready = 1'b0; bus8.rvalid = 1'b0; bus8.rdata = '0; bus8.rlast = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_b8 = 1'b0;
        bus8.awready = 1'b0; bus8.wready = 1'b0; bus8.bvalid = 1'b0;
      end else begin
        bus8.bvalid = pend_b8;
        if (pend_b8 && bus8.bready) pend_b8 = 1'b0;
        bus8.awready = 1'b1;
        bus8.wready  = 1'b1;
        if (bus8.wvalid && bus8.wlast) pend_b8 = 1'b1;
      end
    end
  end

  // Monitor for the MODE=1 instance: handshakes are sampled just after the negedge, where
  // both valid and ready already hold the values the next rising edge will see.
  initial begin
    logic pv_aw, pv_w;
    logic [26:0] p_aw;
    logic [32:0] p_w;
    logic [31:0] e;
    logic [32:0] ew;
    logic [16:0] ed;
    pv_aw = 1'b0; pv_w = 1'b0; p_aw = '0; p_w = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        pv_aw = 1'b0; pv_w = 1'b0;
      end else begin
        if (pv_aw) chk("aw_stall_hold", {bus.awvalid, bus.awaddr}, {1'b1, p_aw});
        if (pv_w) chk("w_stall_hold", {bus.wvalid, bus.wlast, bus.wdata}, {1'b1, p_w});
        pv_aw = bus.awvalid && !bus.awready;
        p_aw  = bus.awaddr;
        pv_w  = bus.wvalid && !bus.wready;
        p_w   = {bus.wlast, bus.wdata};
        if (bus.awvalid && bus.wvalid) fail("aw_w_overlap");
        if (bus.awvalid && bus.awready) begin
          if (q_aw.size() == 0) fail("aw_unexpected");
          else begin
            e = q_aw.pop_front();
            chk("awaddr", 32'(bus.awaddr), e);
            chk("awlen", bus.awlen, 8'd7);
          end
          if (lat_en && last_aw >= 0) chk("write_burst_cycles", cyc - last_aw, 10);
          last_aw = cyc;
        end
        if (bus.wvalid && bus.wready) begin
          if (q_w.size() == 0) fail("w_unexpected");
          else begin
            ew = q_w.pop_front();
            chk("wlast_wdata", {bus.wlast, bus.wdata}, ew);
          end
        end
        if (bus.arvalid && bus.arready) begin
          if (q_ar.size() == 0) fail("ar_unexpected");
          else begin
            e = q_ar.pop_front();
            chk("araddr", 32'(bus.araddr), e);
            chk("arlen", bus.arlen, 8'd7);
          end
        end
        if (done) begin
          chk("done_busy", busy, 1'b0);
          if (q_done.size() == 0) fail("done_unexpected");
          else begin
            ed = q_done.pop_front();
            chk("done_pass_err", {pass, err_cnt}, ed);
          end
        end
      end
    end
  end

  // Monitor for the MODE=0 instance
  initial begin
    logic [31:0] e;
    logic [32:0] ew;
    logic [16:0] ed;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (bus8.arvalid) fail("w8_arvalid");
        if (bus8.awvalid && bus8.awready) begin
          if (q_aw8.size() == 0) fail("aw8_unexpected");
          else begin
            e = q_aw8.pop_front();
            chk("awaddr8", 32'(bus8.awaddr), e);
            chk("awlen8", bus8.awlen, 8'd0);
          end
        end
        if (bus8.wvalid && bus8.wready) begin
          if (q_w8.size() == 0) fail("w8_unexpected");
          else begin
            ew = q_w8.pop_front();
            chk("wlast_wdata8", {bus8.wlast, bus8.wdata}, ew);
          end
        end
        if (done8) begin
          if (q_done8.size() == 0) fail("done8_unexpected");
          else begin
            ed = q_done8.pop_front();
            chk("done8_pass_err", {pass8, err_cnt8}, ed);
          end
        end
      end
    end
  end

  task automatic wait_done(input int sel, input int budget, output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      start  = 1'b0;
      start8 = 1'b0;
      #2;
      cycles++;
      if ((sel == 0) ? done : done8) break;
      if (cycles >= budget) begin
        fail("done_timeout");
        break;
      end
    end
  endtask

  task automatic run(input int sel, input int budget, output int cycles);
    @(negedge clk);
    last_aw = -1;
    rd_glob = 0;
    if (sel == 0) start = 1'b1;
    else start8 = 1'b1;
    wait_done(sel, budget, cycles);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; start8 = 1'b0; init_end = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
    chk("rst_status", {busy, done, pass, err_cnt}, 19'd0);
    chk("rst_awaddr_awlen", {bus.awaddr, bus.awlen, bus.araddr, bus.arlen}, 70'd0);
    chk("rst_wdata_wlast", {bus.wdata, bus.wlast}, 33'd0);
    @(negedge clk);
    rst = 1'b0;

    // Clean write + read-check run
    lat_en = 1'b1;
    push_run0(1'b1, 16'd0);
    run(0, 300, c);
    chk("t1_done_cycle", c, 77);
    repeat (3) @(negedge clk);
    #1;
    chk("t1_pass_held", {pass, busy, done, err_cnt}, {1'b1, 1'b0, 1'b0, 16'd0});

    // Read beat 10 corrupted
    corrupt_idx = 10;
    push_run0(1'b0, 16'd1);
    run(0, 300, c);
    chk("t2_done_cycle", c, 77);
    repeat (3) @(negedge clk);
    #1;
    chk("t2_fail_held", {pass, err_cnt}, {1'b0, 16'd1});
    corrupt_idx = -1;

    // start held while init_end is low
    push_run0(1'b1, 16'd0);
    @(negedge clk);
    init_end = 1'b0;
    start = 1'b1;
    last_aw = -1;
    rd_glob = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("t3_blocked", {bus.awvalid, busy}, 2'b00);
    end
    init_end = 1'b1;
    @(negedge clk);
    #1;
    chk("t3_aw_after_init", {bus.awvalid, busy}, 2'b11);
    wait_done(0, 300, c);

    // Random stalls on awready/wready/rvalid
    lat_en = 1'b0;
    stall_en = 1'b1;
    push_run0(1'b1, 16'd0);
    run(0, 3000, c);
    stall_en = 1'b0;

    // Narrow-address write-only instance, BURST_LEN=1, address wrap
    push_run8();
    run(1, 100, c);
    chk("t5_done_cycle", c, 10);
    @(negedge clk);
    #1;
    chk("t5_done_pulse", {done8, busy8}, 2'b00);

    // Reset during beat 3 of burst 1, then restart
    lat_en = 1'b1;
    push_run0(1'b1, 16'd0);
    @(negedge clk);
    last_aw = -1;
    rd_glob = 0;
    start = 1'b1;
    c = 0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      #2;
      c++;
      if (bus.wvalid && bus.wdata == SEED0 + 32'd11) break;
      if (c >= 100) begin
        fail("t6_beat_timeout");
        break;
      end
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_reset_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
    chk("t6_reset_status", {busy, done}, 2'b00);
    q_aw.delete(); q_w.delete(); q_ar.delete(); q_done.delete();
    @(negedge clk);
    rst = 1'b0;
    push_run0(1'b1, 16'd0);
    run(0, 300, c);
    chk("t6_done_cycle", c, 77);

    repeat (2) @(negedge clk);
    chk("sb_empty", {32'(q_aw.size()), 32'(q_w.size())}, 64'd0);
    chk("sb_empty_rd", {32'(q_ar.size()), 32'(q_done.size())}, 64'd0);
    chk("sb8_empty", {32'(q_aw8.size() + q_w8.size()), 32'(q_done8.size())}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_traffic_gen.md
Name: axi_traffic_gen

Overview:
- Parametrised AXI-style traffic master for the DDR2 controller bench and bring-up.
- Succeeds the single-burst write-only stimulus master.
- Issues NUM_BURSTS write bursts of BURST_LEN beats at strided addresses, with a deterministic data pattern.
- In MODE=1 it then reads every burst back, checks each beat against the expected pattern, and reports done, pass/fail and an error count.

Parameters:
- ADDR_WIDTH, 27: AXI address width (ROW_BITS+COL_BITS+BA_BITS).
- DATA_WIDTH, 32: data width (2×DQ_BITS).
- BURST_LEN, 8: beats per burst, range 1..256.
- NUM_BURSTS, 4: bursts per run, range ≥1.
- START_ADDR, 0: address of burst 0.
- ADDR_STRIDE, 64: address increment between consecutive bursts.
- SEED, 32'h0000_0000: data pattern offset.
- MODE, 1: 0 = write only, 1 = write all then read-check all.

Ports:
- clk, input, 1: single clock, all logic on rising edge.
- rst, input, 1: synchronous active-high reset.
- start, input, 1: run trigger, level or pulse.
- init_end, input, 1: controller init complete. start is ignored while low.
- awvalid, output, 1: write address valid.
- awready, input, 1: write address ready.
- awaddr, output, ADDR_WIDTH: write burst address.
- awlen, output, 8: BURST_LEN-1.
- wvalid, output, 1: write data valid.
- wready, input, 1: write data ready.
- wdata, output, DATA_WIDTH: write beat data.
- wlast, output, 1: final beat of the burst.
- bvalid, input, 1: write response valid.
- bready, output, 1: write response ready.
- arvalid, output, 1: read address valid.
- arready, input, 1: read address ready.
- araddr, output, ADDR_WIDTH: read burst address.
- arlen, output, 8: BURST_LEN-1.
- rvalid, input, 1: read data valid.
- rready, output, 1: read data ready.
- rdata, input, DATA_WIDTH: read beat data.
- rlast, input, 1: read final beat.
- busy, output, 1: run in progress.
- done, output, 1: one-cycle pulse at end of run.
- pass, output, 1: err_cnt==0 at done. Held until next start.
- err_cnt, output, 16: saturating mismatch count.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset values: all valid/ready outputs, busy, done and pass are 0. Addresses, awlen/arlen, wdata and err_cnt are 0.
- Reset asserted mid-run aborts immediately: FSM returns to IDLE and outstanding handshakes are dropped.
- FSM states: IDLE, AW, W, B, AR, R, FIN.
- IDLE: when start=1 and init_end=1, go to AW next cycle. On entry to AW: busy=1, burst index b=0, beat counters g=0 and rg=0, err_cnt=0, pass=0. Start is ignored while busy or while init_end=0.
- Burst address = START_ADDR + b×ADDR_STRIDE, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
- AW: awvalid=1 with awaddr and awlen stable until awready. On handshake go to W.
- W: wvalid=1 continuously. wdata = SEED + g, modulo 2^DATA_WIDTH.
  - On each wvalid&&wready, increment g.
  - wlast=1 exactly on beat BURST_LEN-1 of the burst.
  - wdata and wlast hold while wready=0.
  - The last-beat handshake goes to B.
- B: bready=1. On bvalid:
  - If b<NUM_BURSTS-1: b+=1, go to AW.
  - Else, if MODE=1: b=0, go to AR.
  - Else (MODE=0): go to FIN.
- AR: arvalid=1 with araddr/arlen held stable until arready, then go to R.
- R: rready=1. On each rvalid beat:
  - Compare rdata with SEED+rg, then increment rg.
  - A mismatch increments err_cnt.
  - rlast on a beat other than BURST_LEN-1, or missing on beat BURST_LEN-1, also increments err_cnt (max one increment per beat).
  - err_cnt saturates at 16'hFFFF.
  - After the last beat: b<NUM_BURSTS-1 → b+=1 and go to AR; else go to FIN.
- FIN: single cycle. done=1, pass=(err_cnt==0, including the current cycle's update), busy=0. Then go to IDLE.
- Only one burst is outstanding at a time; no AW/W overlap. AW and W never assert together.
- Latency: first awvalid 1 cycle after the accepted start. With zero-stall slaves, each write burst takes 1 + BURST_LEN + 1 cycles (AW, W beats, B).
- BURST_LEN=1: wlast is asserted on the only beat.
- bvalid arriving early (before state B) is not accepted; bready is asserted only in B.

Test Plan:
- MODE=1, BURST_LEN=8, NUM_BURSTS=4, STRIDE=64, START=0, ideal memory slave, init_end=1, start pulse → awaddr 0,64,128,192 with awlen=7; wdata 0..31; wlast on g=7,15,23,31; araddr same sequence; done pulse, pass=1, err_cnt=0.
- Same setup, slave corrupts read beat rg=10 (flips bit 0) → err_cnt=1, pass=0 at done.
- start=1 while init_end=0 → no awvalid, busy=0. Raise init_end with start held → awvalid on next cycle.
- Random awready/wready/rvalid stalls (50%) → awaddr/wdata/wlast stable during stalls, beat counts exact, pass=1.
- ADDR_WIDTH=8, START_ADDR=8'hF0, STRIDE=16, NUM_BURSTS=3, MODE=0 → awaddr F0, 00, 10; no arvalid; done after 3rd B.
- Assert rst during W beat 3 of burst 1 → next cycle all valids=0, busy=0, state IDLE; a new start restarts from b=0, wdata=SEED.
